rv_regfile_mp: RTL and testbench

- Parametrised multi-port integer register file for the RISC-V core; next generation of the single-write, two-read file.
- Configurable data width, depth, read-port count and write-port count, for dual-issue writeback.
- Adds same-cycle write-to-read bypass, deterministic write-port priority with conflict reporting, and a sequenced soft clear (context flush) with a busy/done handshake.
- Sits in the Decode stage. Read ports feed operand muxes; write ports are driven from Writeback.

---
 rtl/rv_regfile_mp_pkg.sv | 13 +
 rtl/rv_regfile_mp_if.sv | 33 +++
 rtl/rv_regfile_mp_arbiter.sv | 30 +++
 rtl/rv_regfile_mp.sv | 137 +++++++++++++
 tb/tb_rv_regfile_mp.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_regfile_mp_pkg.sv
// Shared core definitions for the multi-port register file.
package rv_core_pkg;

  localparam int RF_XLEN      = 32;
  localparam int RF_NREGS     = 32;
  localparam int ZERO_REG_IDX = 0;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_clr_state_t;

endpackage

// File: rtl/rv_regfile_mp_if.sv
// Write/read/clear bundle between Decode/Writeback and the register file.
interface rv_regfile_mp_if
  import rv_core_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_sel;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NRD*AW-1:0]   rd_sel;
  logic [NRD*XLEN-1:0] rd_data;
  logic                clr_req;
  logic                busy;
  logic                clr_done;
  logic                wr_conflict;
  logic                wr_drop;

  modport master (
    output wr_en, wr_sel, wr_data, rd_sel, clr_req,
    input  rd_data, busy, clr_done, wr_conflict, wr_drop
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, rd_sel, clr_req,
    output rd_data, busy, clr_done, wr_conflict, wr_drop
  );

endinterface

// File: rtl/rv_regfile_mp_arbiter.sv
// Resolves which write port (if any) targets one address; highest index wins.
module rf_write_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NWR  = 2
) (
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_sel,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [AW-1:0]       addr,
  output logic                hit,
  output logic [XLEN-1:0]     data,
  output logic                conflict
);

  // Ascending scan so a later (higher) port overwrites the selection.
  always_comb begin
    hit      = 1'b0;
    data     = '0;
    conflict = 1'b0;
    for (int unsigned k = 0; k < NWR; k++) begin
      if (wr_en[k] && (wr_sel[k*AW +: AW] == addr)) begin
        if (hit) conflict = 1'b1;
        hit  = 1'b1;
        data = wr_data[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/rv_regfile_mp.sv
// Multi-port integer register file with bypass, write priority and soft clear.
module rv_regfile_mp
  import rv_core_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NREGS    = RF_NREGS,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic             clock,
  input  logic             reset,
  rv_regfile_mp_if.slave   bus
);

  localparam int            AW       = $clog2(NREGS);
  localparam logic [AW:0]   LAST_IDX = (AW+1)'(NREGS - 1);
  localparam logic [AW-1:0] ZIDX     = AW'(ZERO_REG_IDX);

  rf_clr_state_t   state, state_nxt;
  logic [AW:0]     clr_idx;
  logic            clr_last;
  logic            busy;
  logic            clr_done_q, wr_conflict_q, wr_drop_q;
  logic            any_conf;

  logic [XLEN-1:0] mem      [NREGS];
  logic [XLEN-1:0] ent_data [NREGS];
  logic [NREGS-1:0] ent_hit, ent_conf, ent_we;

  // One arbiter per entry; its result drives both the write path and the bypass mux.
  for (genvar i = 0; i < NREGS; i++) begin : g_arb
    rf_write_arbiter #(
      .XLEN (XLEN),
      .AW   (AW),
      .NWR  (NWR)
    ) u_arb (
      .wr_en    (bus.wr_en),
      .wr_sel   (bus.wr_sel),
      .wr_data  (bus.wr_data),
      .addr     (AW'(i)),
      .hit      (ent_hit[i]),
      .data     (ent_data[i]),
      .conflict (ent_conf[i])
    );
  end

  assign clr_last = (clr_idx == LAST_IDX);

  // Clear FSM next-state and busy decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    unique case (state)
      RF_IDLE: begin
        if (bus.clr_req) state_nxt = RF_CLEAR;
      end
      RF_CLEAR: begin
        busy = 1'b1;
        if (clr_last) state_nxt = RF_IDLE;
      end
      default: state_nxt = RF_IDLE;
    endcase
  end

  // Clear FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= RF_IDLE;
    else       state <= state_nxt;
  end

  // Clear index walks every entry while in CLEAR, parked at zero otherwise.
  always_ff @(posedge clock) begin
    if (reset || (state != RF_CLEAR) || clr_last) clr_idx <= '0;
    else                                          clr_idx <= clr_idx + 1'b1;
  end

  // Per-entry write enables and the aggregated conflict, ignoring the zero entry.
  always_comb begin
    any_conf = 1'b0;
    ent_we   = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (!((ZERO_REG != 0) && (AW'(i) == ZIDX))) begin
        any_conf  = any_conf | ent_conf[i];
        ent_we[i] = ent_hit[i] & ~busy;
      end
    end
  end

  // Storage: reset zeroes all, CLEAR zeroes one entry per cycle, else commit writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (busy && (clr_idx[AW-1:0] == AW'(i))) mem[i] <= '0;
        else if (ent_we[i])                      mem[i] <= ent_data[i];
      end
    end
  end

  // Registered status pulses describing the previous cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      clr_done_q    <= 1'b0;
      wr_conflict_q <= 1'b0;
      wr_drop_q     <= 1'b0;
    end else begin
      clr_done_q    <= (state == RF_CLEAR) && clr_last;
      wr_conflict_q <= ~busy & any_conf;
      wr_drop_q     <= busy & (|bus.wr_en);
    end
  end

  assign bus.busy        = busy;
  assign bus.clr_done    = clr_done_q;
  assign bus.wr_conflict = wr_conflict_q;
  assign bus.wr_drop     = wr_drop_q;

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [AW-1:0]   sel;
    logic [XLEN-1:0] val;

    assign sel = bus.rd_sel[r*AW +: AW];

    // Read mux: zero entry, then same-cycle bypass (idle only), then storage.
    always_comb begin
      val = mem[sel];
      if ((ZERO_REG != 0) && (sel == ZIDX))            val = '0;
      else if ((BYPASS != 0) && !busy && ent_hit[sel]) val = ent_data[sel];
    end

    assign bus.rd_data[r*XLEN +: XLEN] = val;
  end

endmodule

// File: tb/tb_rv_regfile_mp.sv
// Scoreboard bench for rv_regfile_mp: one bypassing and one non-bypassing instance.
module tb_rv_regfile_mp;
  import rv_core_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  typedef struct {
    string       tag;
    int          sig;
    logic [63:0] exp;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rv_regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) ifa ();
  rv_regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) ifb ();

  assign ifb.wr_en   = ifa.wr_en;
  assign ifb.wr_sel  = ifa.wr_sel;
  assign ifb.wr_data = ifa.wr_data;
  assign ifb.rd_sel  = ifa.rd_sel;
  assign ifb.clr_req = ifa.clr_req;

  rv_regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1)
  ) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifa.slave)
  );

  rv_regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0), .ZERO_REG(1)
  ) u_dut_nb (
    .clock (clock),
    .reset (reset),
    .bus   (ifb.slave)
  );

  exp_t            sb [$];
  int              n_checks = 0;
  int              n_fail   = 0;
  logic [XLEN-1:0] model [NREGS];
  int              pend_addr [$];
  logic [XLEN-1:0] pend_data [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] observe(input int sig);
    case (sig)
      0:       return 64'(ifa.rd_data[31:0]);
      1:       return 64'(ifa.rd_data[63:32]);
      2:       return 64'(ifb.rd_data[31:0]);
      3:       return 64'(ifb.rd_data[63:32]);
      4:       return 64'(ifa.busy);
      5:       return 64'(ifa.clr_done);
      6:       return 64'(ifa.wr_conflict);
      7:       return 64'(ifa.wr_drop);
      default: return '1;
    endcase
  endfunction

  task automatic sb_push(input string tag, input int sig, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drive_idle();
    ifa.wr_en   = '0;
    ifa.wr_sel  = '0;
    ifa.wr_data = '0;
    ifa.rd_sel  = '0;
    ifa.clr_req = 1'b0;
  endtask

  task automatic set_wr(input int p, input int addr, input logic [XLEN-1:0] d);
    ifa.wr_en[p]                 = 1'b1;
    ifa.wr_sel[p*AW +: AW]       = 5'(addr);
    ifa.wr_data[p*XLEN +: XLEN]  = d;
    pend_addr.push_back(addr);
    pend_data.push_back(d);
  endtask

  task automatic set_rd(input int p, input int addr);
    ifa.rd_sel[p*AW +: AW] = 5'(addr);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) model[i] = '0;
  endtask

  // Sample on the falling edge, then advance; queued writes land in the model
  // in port order (later port wins) only when the cycle was expected to commit.
  task automatic step(input bit commit);
    exp_t e;
    @(negedge clock);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sig), e.exp);
    end
    @(posedge clock);
    #1;
    while (pend_addr.size() != 0) begin
      int a;
      logic [XLEN-1:0] d;
      a = pend_addr.pop_front();
      d = pend_data.pop_front();
      if (commit && a != 0) model[a] = d;
    end
  endtask

  initial begin
    model_clear();
    drive_idle();
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Reset state
    set_rd(0, 5);
    sb_push("rst_busy", 4, 0);
    sb_push("rst_done", 5, 0);
    sb_push("rst_conf", 6, 0);
    sb_push("rst_drop", 7, 0);
    sb_push("rst_rd", 0, 0);
    step(1);
    reset = 1'b0;
    drive_idle();

    // Basic write then read; bypass on port 0 in the write cycle
    set_wr(0, 5, 32'hDEADBEEF);
    set_rd(0, 5);
    set_rd(1, 5);
    sb_push("byp0_same", 0, 32'hDEADBEEF);
    sb_push("nobyp0_same", 2, 0);
    step(1);
    drive_idle();
    set_rd(0, 5);
    set_rd(1, 0);
    sb_push("rd_x5", 0, model[5]);
    sb_push("rd_x0", 1, 0);
    step(1);
    drive_idle();

    // Port 1 bypass vs. stored-only read
    set_wr(1, 7, 32'h12345678);
    set_rd(1, 7);
    sb_push("byp1_same", 1, 32'h12345678);
    sb_push("nobyp1_same", 3, model[7]);
    step(1);
    drive_idle();
    set_rd(1, 7);
    sb_push("rd_x7_byp", 1, model[7]);
    sb_push("rd_x7_nobyp", 3, model[7]);
    step(1);
    drive_idle();

    // Write conflict on x3, then both ports on x0
    set_wr(0, 3, 32'h1);
    set_wr(1, 3, 32'h2);
    set_rd(0, 3);
    sb_push("byp_prio", 0, 32'h2);
    sb_push("conf_pre", 6, 0);
    step(1);
    drive_idle();
    set_rd(0, 3);
    sb_push("prio_x3", 0, model[3]);
    sb_push("conf_pulse", 6, 1);
    set_wr(0, 0, 32'hAAAA5555);
    set_wr(1, 0, 32'h5555AAAA);
    set_rd(1, 0);
    sb_push("x0_byp", 1, 0);
    step(1);
    drive_idle();
    set_rd(1, 0);
    sb_push("conf_x0", 6, 0);
    sb_push("x0_rd", 1, 0);
    step(1);
    drive_idle();

    // Fill x1..x31 with distinct nonzero values, two ports per cycle
    for (int i = 1; i < NREGS; i += 2) begin
      set_wr(0, i, 32'hC0DE0000 + 32'(i * 257));
      if (i + 1 < NREGS) set_wr(1, i + 1, 32'hC0DE0000 + 32'((i + 1) * 257));
      sb_push("fill_noconf", 6, 0);
      step(1);
      drive_idle();
    end
    for (int i = 0; i < NREGS; i += 2) begin
      set_rd(0, i);
      set_rd(1, i + 1);
      sb_push("fill_rd0", 0, model[i]);
      sb_push("fill_rd1", 1, model[i + 1]);
      step(1);
      drive_idle();
    end

    // Soft clear: single-cycle request, write mid-clear dropped, re-request ignored
    ifa.clr_req = 1'b1;
    sb_push("clr_req_cycle", 4, 0);
    step(1);
    drive_idle();
    for (int c = 0; c < NREGS; c++) begin
      sb_push("clr_busy", 4, 1);
      sb_push("clr_done_lo", 5, 0);
      sb_push("clr_drop", 7, (c == 6) ? 64'd1 : 64'd0);
      if (c == 5) begin
        set_wr(0, 9, 32'hBAD0BAD0);
        set_rd(0, 9);
        sb_push("clr_nobyp", 0, model[9]);
      end
      if (c == 10) ifa.clr_req = 1'b1;
      step(0);
      drive_idle();
    end
    model_clear();
    sb_push("clr_done_hi", 5, 1);
    sb_push("clr_idle", 4, 0);
    sb_push("clr_drop_end", 7, 0);
    step(1);
    drive_idle();
    sb_push("clr_done_once", 5, 0);
    sb_push("clr_no_requeue", 4, 0);
    step(1);
    for (int i = 0; i < NREGS; i += 2) begin
      set_rd(0, i);
      set_rd(1, i + 1);
      sb_push("clr_rd0", 0, model[i]);
      sb_push("clr_rd1", 1, model[i + 1]);
      step(1);
      drive_idle();
    end

    // Reset during CLEAR aborts without clr_done; untouched high entries reset
    set_wr(0, 20, 32'h20202020);
    set_wr(1, 21, 32'h21212121);
    step(1);
    drive_idle();
    set_wr(0, 22, 32'h22222222);
    set_wr(1, 23, 32'h23232323);
    step(1);
    drive_idle();
    ifa.clr_req = 1'b1;
    step(1);
    drive_idle();
    for (int c = 0; c < 10; c++) begin
      sb_push("rst_mid_busy", 4, 1);
      step(0);
    end
    reset = 1'b1;
    sb_push("rst_mid_busy10", 4, 1);
    step(0);
    reset = 1'b0;
    model_clear();
    sb_push("rst_abort_busy", 4, 0);
    step(1);
    for (int c = 0; c < 40; c++) begin
      sb_push("rst_abort_nodone", 5, 0);
      sb_push("rst_abort_idle", 4, 0);
      step(1);
    end
    for (int i = 20; i < 24; i += 2) begin
      set_rd(0, i);
      set_rd(1, i + 1);
      sb_push("rst_rd0", 0, model[i]);
      sb_push("rst_rd1", 1, model[i + 1]);
      step(1);
      drive_idle();
    end

    // Write presented in the request cycle commits, then is cleared
    set_wr(0, 4, 32'hA);
    ifa.clr_req = 1'b1;
    step(1);
    drive_idle();
    set_rd(0, 4);
    sb_push("req_wr_x4", 0, 32'hA);
    sb_push("req_busy0", 4, 1);
    step(0);
    for (int c = 1; c < NREGS; c++) begin
      sb_push("req_busy", 4, 1);
      step(0);
    end
    model_clear();
    set_rd(0, 4);
    sb_push("req_done", 5, 1);
    sb_push("req_x4_clr", 0, model[4]);
    step(1);
    drive_idle();

    // Held request re-triggers from the first IDLE cycle
    ifa.clr_req = 1'b1;
    step(1);
    for (int c = 0; c < NREGS; c++) begin
      sb_push("held_busy", 4, 1);
      step(0);
    end
    sb_push("held_done", 5, 1);
    sb_push("held_idle", 4, 0);
    step(1);
    sb_push("held_retrig", 4, 1);
    step(0);
    drive_idle();
    reset = 1'b1;
    step(0);
    reset = 1'b0;
    sb_push("final_idle", 4, 0);
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
